// File: rtl/tone_bank_pkg.sv
// Shared constants for the tone bank: the default note scale, the reset
// divider calculation and the write-address width helper.
package tone_bank_pkg;

    localparam int N_NOTES = 8;

    // C4..C5 scale in micro-hertz so the reset dividers need only integer math.
    localparam longint NOTE_UHZ [N_NOTES] = '{
        longint'(261625600), longint'(293664800), longint'(329627600), longint'(349228200),
        longint'(391995400), longint'(440000000), longint'(493883300), longint'(523251100)
    };

    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // CLOCK / (f * SAMPLE_SIZE), truncated; channels beyond the scale are silent.
    function automatic logic [31:0] default_div(input int ch, input longint clock,
                                                input longint sample_size);
        longint den;
        if (ch < 0 || ch >= N_NOTES) begin
            return '0;
        end
        den = NOTE_UHZ[ch] * sample_size;
        if (den <= 0) begin
            return '0;
        end
        return 32'((clock * longint'(1000000)) / den);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave channel: half-period counter, active/shadow divider pair
// and a pending flag so divider changes only land on a half-period boundary.
module tone_channel
    import tone_bank_pkg::*;
#(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_data,
    output logic             note,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] shd_div;
    logic             running;
    logic             at_end;
    logic             wrap;
    logic             apply;

    assign running = en && (act_div != '0);
    assign at_end  = (cnt == act_div - DIV_W'(1));
    assign wrap    = running && at_end;
    // A stopped channel has no half-period to protect, so it takes the shadow at once.
    assign apply   = pending && (wrap || !running);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            note    <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            act_div <= RST_DIV;
            shd_div <= RST_DIV;
        end else begin
            if (sync) begin
                act_div <= wr ? wr_data : shd_div;
                shd_div <= wr ? wr_data : shd_div;
                pending <= 1'b0;
            end else begin
                if (apply) begin
                    act_div <= shd_div;
                end
                // A write landing on the apply edge stays queued for the next boundary.
                if (wr) begin
                    shd_div <= wr_data;
                    pending <= 1'b1;
                end else if (apply) begin
                    pending <= 1'b0;
                end
            end

            if (sync || !running) begin
                cnt  <= '0;
                note <= 1'b0;
                tick <= 1'b0;
            end else if (at_end) begin
                cnt  <= '0;
                note <= ~note;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tone_bank.sv
// Bank of N_CH programmable square-wave channels; decodes the divider write
// port, fans out sync and supplies each channel its reset divider.
module tone_bank
    import tone_bank_pkg::*;
#(
    parameter int CLOCK       = 50000000,
    parameter int SAMPLE_SIZE = 512,
    parameter int N_CH        = 8,
    parameter int DIV_W       = 16,
    parameter int ADDR_W      = addr_bits(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W-1:0]  wr_data,
    output logic [N_CH-1:0]   notas,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    logic [N_CH-1:0] wr_hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [DIV_W-1:0] RST_DIV =
            DIV_W'(default_div(i, longint'(CLOCK), longint'(SAMPLE_SIZE)));

        // Out-of-range addresses match no channel and are dropped.
        assign wr_hit[i] = wr_en && (32'(wr_addr) == i);

        tone_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_hit[i]),
            .wr_data (wr_data),
            .note    (notas[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule
